// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - FSM state encoding and default pattern constants for the sequence detector arbiter
package seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_LOAD  = 2'd1;
    localparam state_t S_SHIFT = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    localparam int                   DEF_PAT_W   = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1001;

endpackage

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - bit-serial pattern detector: history shift register, bits_seen qualifier, hit output
module seq_det_core
    import seq_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic din,
    output logic hit
);

    localparam int SEEN_W = $clog2(PAT_W);

    logic [PAT_W-2:0]  hist;
    logic [SEEN_W-1:0] bits_seen;
    logic [PAT_W-1:0]  window;

    assign window = {hist, din};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist      <= '0;
            bits_seen <= '0;
        end else if (clear) begin
            hist      <= '0;
            bits_seen <= '0;
        end else if (en) begin
            hist <= window[PAT_W-2:0];
            // Saturates once the window is full so the qualifier stays true
            if (bits_seen != SEEN_W'(PAT_W-1))
                bits_seen <= bits_seen + SEEN_W'(1);
        end
    end

    assign hit = en && (window == PATTERN) && (bits_seen == SEEN_W'(PAT_W-1));

endmodule

// File: rtl/seq_det_arbiter.sv
// rtl/seq_det_arbiter.sv - round-robin arbiter feeding frames MSB-first into a shared pattern detector
// Optional: SEQ_EARLY_ABORT_EN ends the scan on the edge after the first qualified hit.
module seq_det_arbiter
    import seq_pkg::*;
#(
    parameter int               NREQ    = 4,
    parameter int               FRAME_W = 16,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    localparam int              CNT_W   = $clog2(FRAME_W+1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*FRAME_W-1:0] frame,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    ser_bit,
    output logic                    hit,
    output logic [NREQ-1:0]         done,
    output logic [CNT_W-1:0]        match_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    state_t             state, state_nxt;
    logic [NREQ-1:0]    gnt_r;
    logic [IDX_W-1:0]   idx, rr_ptr, pick_idx;
    logic               pick_found;
    int                 cand;
    logic [FRAME_W-1:0] shreg;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   count;
    logic               last_bit;
    logic               core_hit;

    assign last_bit = (bit_cnt == BIT_W'(FRAME_W-1));

    // First requester strictly after the rr pointer, wrapping around
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!pick_found && req[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_found) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: begin
`ifdef SEQ_EARLY_ABORT_EN
                if (last_bit || core_hit) state_nxt = S_DONE;
`else
                if (last_bit) state_nxt = S_DONE;
`endif
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_r     <= '0;
            idx       <= '0;
            rr_ptr    <= IDX_W'(NREQ-1);
            shreg     <= '0;
            bit_cnt   <= '0;
            count     <= '0;
            match_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        idx   <= pick_idx;
                        gnt_r <= NREQ'(1) << pick_idx;
                    end
                end
                S_LOAD: begin
                    shreg   <= frame[int'(idx)*FRAME_W +: FRAME_W];
                    bit_cnt <= '0;
                    count   <= '0;
                end
                S_SHIFT: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    count   <= count + CNT_W'(core_hit);
                    // Result includes the final bit so it is valid alongside done
                    if (state_nxt == S_DONE)
                        match_cnt <= count + CNT_W'(core_hit);
                end
                S_DONE: begin
                    rr_ptr <= idx;
                    gnt_r  <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy    = (state != S_IDLE);
        ser_bit = 1'b0;
        done    = '0;
        case (state)
            S_SHIFT: ser_bit = shreg[FRAME_W-1];
            S_DONE:  done    = gnt_r;
            default: ;
        endcase
    end

    assign gnt = gnt_r;
    assign hit = core_hit;

    seq_det_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .clear (state == S_LOAD),
        .en    (state == S_SHIFT),
        .din   (ser_bit),
        .hit   (core_hit)
    );

endmodule

// File: tb/tb_seq_det_arbiter.sv
// tb/tb_seq_det_arbiter.sv - scoreboard bench for seq_det_arbiter (two pattern configurations)
module tb_seq_det_arbiter;

    localparam int NREQ    = 4;
    localparam int FRAME_W = 16;
    localparam int CNT_W   = 5;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NREQ-1:0]         req = '0, req_b = '0;
    logic [NREQ*FRAME_W-1:0] frame = '0, frame_b = '0;
    logic [NREQ-1:0]         gnt, gnt_b, done, done_b;
    logic                    busy, busy_b, ser_bit, ser_bit_b, hit, hit_b;
    logic [CNT_W-1:0]        match_cnt, match_cnt_b;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seq_det_arbiter #(.NREQ(NREQ), .FRAME_W(FRAME_W), .PAT_W(4), .PATTERN(4'b1001)) u_dut (
        .clk(clk), .reset(reset), .req(req), .frame(frame), .gnt(gnt), .busy(busy),
        .ser_bit(ser_bit), .hit(hit), .done(done), .match_cnt(match_cnt)
    );

    seq_det_arbiter #(.NREQ(NREQ), .FRAME_W(FRAME_W), .PAT_W(4), .PATTERN(4'b0001)) u_alt (
        .clk(clk), .reset(reset), .req(req_b), .frame(frame_b), .gnt(gnt_b), .busy(busy_b),
        .ser_bit(ser_bit_b), .hit(hit_b), .done(done_b), .match_cnt(match_cnt_b)
    );

    function automatic int count_pat(input logic [15:0] f, input logic [3:0] p);
        int c = 0;
        for (int i = 0; i <= FRAME_W - 4; i++)
            if (f[15-i -: 4] == p) c++;
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input logic [15:0] f, input logic [3:0] p);
        int c = count_pat(f, p);
`ifdef SEQ_EARLY_ABORT_EN
        if (c > 1) c = 1;
`endif
        return CNT_W'(c);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Observes one service: grant, done vector, result, latency (LOAD cycle = 1), hit positions by SHIFT clk
    task automatic wait_done(input bit sel, output int n, output logic [NREQ-1:0] g,
                             output logic [NREQ-1:0] dv, output logic [CNT_W-1:0] mc,
                             output logic [31:0] hits, output int idle_cnt);
        int               n0;
        logic             bz, ht;
        logic [NREQ-1:0]  gg, dd;
        bit               found;
        n = -1; n0 = 0; g = '0; dv = '0; mc = '0; hits = '0; idle_cnt = 0; found = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            bz = sel ? busy_b : busy;
            ht = sel ? hit_b  : hit;
            gg = sel ? gnt_b  : gnt;
            dd = sel ? done_b : done;
            if (!bz) idle_cnt++;
            if (g == '0 && gg != '0) begin
                g  = gg;
                n0 = c;
            end
            if (ht && n0 > 0) hits[c-n0] = 1'b1;
            if (dd != '0) begin
                dv    = dd;
                mc    = sel ? match_cnt_b : match_cnt;
                n     = c - n0 + 1;
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL done_timeout: got no done within 100 cycles, expected a done pulse");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt, done, busy, ser_bit, hit} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %0h expected 0", {gnt, done, busy, ser_bit, hit});
        end
        checks++;
        if (match_cnt !== '0) begin
            errors++;
            $display("FAIL reset_match_cnt: got %0d expected 0", match_cnt);
        end
        do_reset();
    endtask

    task automatic test_single();
        int n, idl; logic [NREQ-1:0] g, dv; logic [CNT_W-1:0] mc; logic [31:0] h; exp_t e;
        do_reset();
        frame[15:0] = 16'h9999;
        exp_q.push_back('{4'b0001, exp_cnt(16'h9999, 4'b1001)});
        req = 4'b0001;
        wait_done(0, n, g, dv, mc, h, idl);
        req = '0;
        e = exp_q.pop_front();
        checks++;
        if (g !== e.gnt) begin errors++; $display("FAIL single_gnt: got %b expected %b", g, e.gnt); end
        checks++;
        if (dv !== e.gnt) begin errors++; $display("FAIL single_done: got %b expected %b", dv, e.gnt); end
        checks++;
        if (mc !== e.cnt) begin errors++; $display("FAIL single_cnt: got %0d expected %0d", mc, e.cnt); end
`ifndef SEQ_EARLY_ABORT_EN
        checks++;
        if (n != FRAME_W + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", n, FRAME_W + 2); end
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (match_cnt !== e.cnt) begin errors++; $display("FAIL single_hold: got %0d expected %0d", match_cnt, e.cnt); end
    endtask

    task automatic test_overlap();
        int n, idl; logic [NREQ-1:0] g, dv; logic [CNT_W-1:0] mc; logic [31:0] h, exp_h; exp_t e;
        do_reset();
        frame[15:0] = 16'b1001001001000000;
        exp_q.push_back('{4'b0001, exp_cnt(16'b1001001001000000, 4'b1001)});
`ifdef SEQ_EARLY_ABORT_EN
        exp_h = 32'h1 << 4;
`else
        exp_h = (32'h1 << 4) | (32'h1 << 7) | (32'h1 << 10);
`endif
        req = 4'b0001;
        wait_done(0, n, g, dv, mc, h, idl);
        req = '0;
        e = exp_q.pop_front();
        checks++;
        if (mc !== e.cnt) begin errors++; $display("FAIL overlap_cnt: got %0d expected %0d", mc, e.cnt); end
        checks++;
        if (h !== exp_h) begin errors++; $display("FAIL overlap_hits: got %h expected %h", h, exp_h); end
        @(negedge clk);
    endtask

    task automatic test_pattern_0001();
        int n, idl; logic [NREQ-1:0] g, dv; logic [CNT_W-1:0] mc; logic [31:0] h; exp_t e;
        logic [15:0] fr [2];
        fr[0] = 16'h1000;
        fr[1] = 16'h0000;
        do_reset();
        for (int t = 0; t < 2; t++) begin
            frame_b[15:0] = fr[t];
            exp_q.push_back('{4'b0001, exp_cnt(fr[t], 4'b0001)});
            req_b = 4'b0001;
            wait_done(1, n, g, dv, mc, h, idl);
            req_b = '0;
            e = exp_q.pop_front();
            checks++;
            if (mc !== e.cnt) begin errors++; $display("FAIL pat0001_cnt%0d: got %0d expected %0d", t, mc, e.cnt); end
            checks++;
            if (h[3:1] !== 3'b000) begin errors++; $display("FAIL pat0001_early_hit%0d: got %b expected 000", t, h[3:1]); end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        int n, idl; logic [NREQ-1:0] g, dv; logic [CNT_W-1:0] mc; logic [31:0] h; exp_t e;
        logic [15:0] fr [NREQ];
        fr[0] = 16'h9999; fr[1] = 16'h9249; fr[2] = 16'h0009; fr[3] = 16'h4F21;
        do_reset();
        for (int i = 0; i < NREQ; i++) frame[i*FRAME_W +: FRAME_W] = fr[i];
        for (int k = 0; k < 5; k++)
            exp_q.push_back('{NREQ'(1) << (k % NREQ), exp_cnt(fr[k % NREQ], 4'b1001)});
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(0, n, g, dv, mc, h, idl);
            if (k == 4) req = '0;
            e = exp_q.pop_front();
            checks++;
            if (g !== e.gnt) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", k, g, e.gnt); end
            checks++;
            if (dv !== e.gnt) begin errors++; $display("FAIL rr_done%0d: got %b expected %b", k, dv, e.gnt); end
            checks++;
            if (mc !== e.cnt) begin errors++; $display("FAIL rr_cnt%0d: got %0d expected %0d", k, mc, e.cnt); end
            if (k > 0) begin
                checks++;
                if (idl != 1) begin errors++; $display("FAIL rr_idle%0d: got %0d expected 1", k, idl); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_priority();
        int n, idl; logic [NREQ-1:0] g, dv; logic [CNT_W-1:0] mc; logic [31:0] h; exp_t e;
        do_reset();
        frame[0*FRAME_W +: FRAME_W] = 16'h9009;
        frame[2*FRAME_W +: FRAME_W] = 16'h1990;
        exp_q.push_back('{4'b0001, exp_cnt(16'h9009, 4'b1001)});
        exp_q.push_back('{4'b0100, exp_cnt(16'h1990, 4'b1001)});
        exp_q.push_back('{4'b0001, exp_cnt(16'h9009, 4'b1001)});
        req = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            wait_done(0, n, g, dv, mc, h, idl);
            if (k == 2) req = '0;
            e = exp_q.pop_front();
            checks++;
            if (g !== e.gnt) begin errors++; $display("FAIL prio_gnt%0d: got %b expected %b", k, g, e.gnt); end
            checks++;
            if (mc !== e.cnt) begin errors++; $display("FAIL prio_cnt%0d: got %0d expected %0d", k, mc, e.cnt); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n, idl; logic [NREQ-1:0] g, dv; logic [CNT_W-1:0] mc; logic [31:0] h; exp_t e;
        bit seen;
        do_reset();
        frame[15:0] = 16'h9999;
        req = 4'b0001;
        wait_done(0, n, g, dv, mc, h, idl);
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (gnt != '0) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_regrant: got no grant expected 0001"); end
        repeat (8) @(negedge clk);
        frame[15:0] = 16'h9990;
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt, done, busy} !== '0) begin errors++; $display("FAIL mid_reset_ctrl: got %h expected 0", {gnt, done, busy}); end
        checks++;
        if (match_cnt !== '0) begin errors++; $display("FAIL mid_reset_cnt: got %0d expected 0", match_cnt); end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back('{4'b0001, exp_cnt(16'h9990, 4'b1001)});
        wait_done(0, n, g, dv, mc, h, idl);
        req = '0;
        e = exp_q.pop_front();
        checks++;
        if (mc !== e.cnt) begin errors++; $display("FAIL mid_fresh_cnt: got %0d expected %0d", mc, e.cnt); end
`ifndef SEQ_EARLY_ABORT_EN
        checks++;
        if (n != FRAME_W + 2) begin errors++; $display("FAIL mid_latency: got %0d expected %0d", n, FRAME_W + 2); end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_overlap();
        test_pattern_0001();
        test_round_robin();
        test_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
